mac_flow_ctrl: RTL and testbench
================================

MAC_FLOW_CTRL -- requirements
Module: mac_flow_ctrl

Interface
REQ-001 Parameter NUM_CH, default 2, number of MAC RX channels monitored (1..8).
REQ-002 Parameter CNT_W, default 16, width of each statistics counter (8..32).
REQ-003 Parameter XOFF_REFRESH, default 1024, cycles between repeated XOFF pulses while paused (>=2).
REQ-004 Parameter ERR_MASK, default 18'h0003F, rx_err_stat bits that classify a frame as errored.
REQ-005 One clock, clk; reset is synchronous and active-high, named reset.
REQ-006 clk  in  1  sole clock.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 ff_rx_a_full  in  NUM_CH  per-channel RX FIFO almost-full level.
REQ-009 ff_rx_a_empty  in  NUM_CH  per-channel RX FIFO almost-empty level.
REQ-010 rx_stat_vld  in  NUM_CH  one-cycle strobe per received frame; qualifies stat/type.
REQ-011 rx_err_stat  in  NUM_CH*18  packed per-channel frame error status.
REQ-012 rx_frm_type  in  NUM_CH*4  packed per-channel frame type; bit 2 = broadcast.
REQ-013 xoff_gen  out  NUM_CH  one-cycle pulse requesting pause frame.
REQ-014 xon_gen  out  NUM_CH  one-cycle pulse requesting pause release.
REQ-015 paused  out  NUM_CH  level, channel in PAUSED state.
REQ-016 rd_en  in  1  counter read request.
REQ-017 rd_ch  in  3  channel select; values >= NUM_CH return zero.
REQ-018 rd_sel  in  2  0=frames, 1=errored, 2=broadcast, 3=xoff count.
REQ-019 rd_data  out  CNT_W  counter value; rd_valid  out  1  qualifies rd_data.

Function
REQ-020 Per-channel FSM states IDLE, PAUSED.
REQ-021 IDLE with a_full=1 -> PAUSED; xoff_gen pulses that cycle+1 (registered), refresh timer loads XOFF_REFRESH-1.
REQ-022 PAUSED: timer decrements each cycle; at 0 with a_full=1, xoff_gen pulses again, timer reloads.
REQ-023 PAUSED with a_empty=1 and a_full=0 -> IDLE; xon_gen pulses one cycle later; timer stops.
REQ-024 a_full and a_empty both 1: a_full wins (stay/enter PAUSED, no xon).
REQ-025 PAUSED with neither level: hold state, timer continues, re-XOFF only if a_full at expiry.
REQ-026 xoff_gen and xon_gen never asserted together on one channel.
REQ-027 On rx_stat_vld: frames+1; errored+1 if |(rx_err_stat & ERR_MASK); broadcast+1 if rx_frm_type[2].
REQ-028 xoff counter +1 per xoff_gen pulse.
REQ-029 All counters saturate at 2^CNT_W-1; no wrap.
REQ-030 Read latency 1: rd_en at cycle N -> rd_valid=1 and rd_data at N+1; rd_data holds its last value when rd_valid=0.
REQ-031 Back-to-back rd_en accepted every cycle.
REQ-032 Read sample reflects counter value before any same-cycle increment.

Reset
REQ-033 reset: all FSMs IDLE, timers 0, counters 0, xoff_gen/xon_gen/paused/rd_valid/rd_data 0.
REQ-034 reset mid-pause: next cycle paused=0, no xon pulse emitted.

Configuration
REQ-035 Macro MAC_FLOW_CTRL_CLR_ON_READ_EN defined: read counter cleared in the read cycle; a same-cycle increment leaves it at 1.
REQ-036 Macro undefined: reads non-destructive; counters cleared only by reset.

Structure
REQ-037 Package mac_flow_ctrl_pkg holds state enum, rd_sel encodings, ERR_STAT_W=18, FRM_TYPE_W=4.
REQ-038 Sub-module mac_flow_ctrl_chan (FSM, timer, four counters) instantiated NUM_CH times by generate.

Verification
REQ-039 ch0 a_full=1 from cycle 10 -> xoff_gen[0] pulse at 11, paused[0]=1 from 11.
REQ-040 XOFF_REFRESH=8, a_full held 20 cycles -> xoff pulses at 11, 19, 27; xoff count reads 3.
REQ-041 a_full drops, a_empty=1 at cycle 40 -> xon_gen pulse at 41, paused=0; a_full=a_empty=1 -> no xon.
REQ-042 CNT_W=8, 300 frames with rx_err_stat=18'h1 -> frames and errored both read 255.
REQ-043 CLR_ON_READ_EN, read frames=5 with same-cycle rx_stat_vld -> rd_data=5, next read 1.
REQ-044 reset asserted in PAUSED -> all outputs 0 next cycle, no xon_gen pulse.

Source files
------------

// File: rtl/mac_flow_ctrl_pkg.sv
// rtl/mac_flow_ctrl_pkg.sv - shared types, encodings and widths for the MAC RX flow controller
package mac_flow_ctrl_pkg;

  localparam int ERR_STAT_W = 18;
  localparam int FRM_TYPE_W = 4;
  localparam int BCAST_BIT  = 2;
  localparam int NUM_CNT    = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_PAUSED = 1'b1
  } fc_state_e;

  // Doubles as the index of each statistics counter inside a channel.
  typedef enum logic [1:0] {
    SEL_FRAMES  = 2'd0,
    SEL_ERRORED = 2'd1,
    SEL_BCAST   = 2'd2,
    SEL_XOFF    = 2'd3
  } rd_sel_e;

endpackage

// File: rtl/mac_flow_ctrl_if.sv
// rtl/mac_flow_ctrl_if.sv - MAC RX level/status inputs, pause outputs and counter read port
interface mac_flow_ctrl_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
);
  import mac_flow_ctrl_pkg::*;

  logic [NUM_CH-1:0]            ff_rx_a_full;
  logic [NUM_CH-1:0]            ff_rx_a_empty;
  logic [NUM_CH-1:0]            rx_stat_vld;
  logic [NUM_CH*ERR_STAT_W-1:0] rx_err_stat;
  logic [NUM_CH*FRM_TYPE_W-1:0] rx_frm_type;
  logic [NUM_CH-1:0]            xoff_gen;
  logic [NUM_CH-1:0]            xon_gen;
  logic [NUM_CH-1:0]            paused;
  logic                         rd_en;
  logic [2:0]                   rd_ch;
  logic [1:0]                   rd_sel;
  logic [CNT_W-1:0]             rd_data;
  logic                         rd_valid;

  modport master (
    output ff_rx_a_full, ff_rx_a_empty, rx_stat_vld, rx_err_stat, rx_frm_type,
    output rd_en, rd_ch, rd_sel,
    input  xoff_gen, xon_gen, paused, rd_data, rd_valid
  );

  modport slave (
    input  ff_rx_a_full, ff_rx_a_empty, rx_stat_vld, rx_err_stat, rx_frm_type,
    input  rd_en, rd_ch, rd_sel,
    output xoff_gen, xon_gen, paused, rd_data, rd_valid
  );

endinterface

// File: rtl/mac_flow_ctrl_chan.sv
// rtl/mac_flow_ctrl_chan.sv - one channel: pause FSM with XOFF refresh timer and four saturating counters
module mac_flow_ctrl_chan
  import mac_flow_ctrl_pkg::*;
#(
  parameter int                    CNT_W        = 16,
  parameter int                    XOFF_REFRESH = 1024,
  parameter logic [ERR_STAT_W-1:0] ERR_MASK     = 18'h0003F
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_full_i,
  input  logic                  a_empty_i,
  input  logic                  stat_vld_i,
  input  logic [ERR_STAT_W-1:0] err_stat_i,
  input  logic                  bcast_i,
  input  logic                  rd_hit_i,
  input  rd_sel_e               rd_sel_i,
  output logic                  xoff_gen_o,
  output logic                  xon_gen_o,
  output logic                  paused_o,
  output logic [CNT_W-1:0]      rd_cnt_o
);

  localparam int               TMR_W      = $clog2(XOFF_REFRESH);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(XOFF_REFRESH - 1);

  fc_state_e          state_q;
  logic [TMR_W-1:0]   timer_q;
  logic               xoff_q;
  logic               xon_q;
  logic [NUM_CNT-1:0] inc;
  logic [CNT_W-1:0]   cnt_q [NUM_CNT];
  logic [CNT_W-1:0]   cnt_d [NUM_CNT];

  // The timer free-runs while paused; an expiry only re-sends XOFF if the FIFO is still almost full.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      xoff_q  <= 1'b0;
      xon_q   <= 1'b0;
    end else begin
      xoff_q <= 1'b0;
      xon_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (a_full_i) begin
            state_q <= ST_PAUSED;
            xoff_q  <= 1'b1;
            timer_q <= TMR_RELOAD;
          end
        end
        ST_PAUSED: begin
          if (a_empty_i && !a_full_i) begin
            state_q <= ST_IDLE;
            xon_q   <= 1'b1;
            timer_q <= '0;
          end else if (timer_q == '0) begin
            xoff_q  <= a_full_i;
            timer_q <= TMR_RELOAD;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign xoff_gen_o = xoff_q;
  assign xon_gen_o  = xon_q;
  assign paused_o   = (state_q == ST_PAUSED);

  assign inc[SEL_FRAMES]  = stat_vld_i;
  assign inc[SEL_ERRORED] = stat_vld_i && (|(err_stat_i & ERR_MASK));
  assign inc[SEL_BCAST]   = stat_vld_i && bcast_i;
  assign inc[SEL_XOFF]    = xoff_q;

  always_comb begin
    for (int k = 0; k < NUM_CNT; k++) begin
      cnt_d[k] = cnt_q[k];
      if (inc[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
`ifdef MAC_FLOW_CTRL_CLR_ON_READ_EN
      if (rd_hit_i && (int'(rd_sel_i) == k)) begin
        cnt_d[k] = {{(CNT_W-1){1'b0}}, inc[k]};
      end
`endif
    end
  end

`ifndef MAC_FLOW_CTRL_CLR_ON_READ_EN
  logic unused_rd_hit;
  assign unused_rd_hit = rd_hit_i;
`endif

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CNT; k++) begin
      if (reset) begin
        cnt_q[k] <= '0;
      end else begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // Read path sees the registered value, i.e. before this cycle's increment.
  assign rd_cnt_o = cnt_q[rd_sel_i];

endmodule

// File: rtl/mac_flow_ctrl.sv
// rtl/mac_flow_ctrl.sv - multi-channel MAC RX pause/statistics block; MAC_FLOW_CTRL_CLR_ON_READ_EN makes reads clear
module mac_flow_ctrl
  import mac_flow_ctrl_pkg::*;
#(
  parameter int                    NUM_CH       = 2,
  parameter int                    CNT_W        = 16,
  parameter int                    XOFF_REFRESH = 1024,
  parameter logic [ERR_STAT_W-1:0] ERR_MASK     = 18'h0003F
) (
  input  logic           clk,
  input  logic           reset,
  mac_flow_ctrl_if.slave bus
);

  logic [CNT_W-1:0]  chan_cnt [NUM_CH];
  logic [NUM_CH-1:0] rd_hit;
  logic [NUM_CH-1:0] xoff_vec;
  logic [NUM_CH-1:0] xon_vec;
  logic [NUM_CH-1:0] paused_vec;
  logic [CNT_W-1:0]  rd_mux;
  logic [CNT_W-1:0]  rd_data_q;
  logic              rd_valid_q;

  // Only the broadcast bit of the frame type matters here.
  logic unused_frm_type;
  assign unused_frm_type = ^bus.rx_frm_type;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    assign rd_hit[g] = bus.rd_en && (int'(bus.rd_ch) == g);

    mac_flow_ctrl_chan #(
      .CNT_W        (CNT_W),
      .XOFF_REFRESH (XOFF_REFRESH),
      .ERR_MASK     (ERR_MASK)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .a_full_i   (bus.ff_rx_a_full[g]),
      .a_empty_i  (bus.ff_rx_a_empty[g]),
      .stat_vld_i (bus.rx_stat_vld[g]),
      .err_stat_i (bus.rx_err_stat[g*ERR_STAT_W +: ERR_STAT_W]),
      .bcast_i    (bus.rx_frm_type[g*FRM_TYPE_W + BCAST_BIT]),
      .rd_hit_i   (rd_hit[g]),
      .rd_sel_i   (rd_sel_e'(bus.rd_sel)),
      .xoff_gen_o (xoff_vec[g]),
      .xon_gen_o  (xon_vec[g]),
      .paused_o   (paused_vec[g]),
      .rd_cnt_o   (chan_cnt[g])
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(bus.rd_ch) == i) begin
        rd_mux = chan_cnt[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_data_q <= rd_mux;
      end
    end
  end

  assign bus.xoff_gen = xoff_vec;
  assign bus.xon_gen  = xon_vec;
  assign bus.paused   = paused_vec;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_mac_flow_ctrl.sv
// tb/tb_mac_flow_ctrl.sv - scoreboard bench for mac_flow_ctrl against a cycle-level reference model
module tb_mac_flow_ctrl;
  import mac_flow_ctrl_pkg::*;

  localparam int          NCH     = 3;
  localparam int          CW      = 8;
  localparam int          REFRESH = 8;
  localparam logic [17:0] MASK    = 18'h0003F;
  localparam int          MAXV    = (1 << CW) - 1;
`ifdef MAC_FLOW_CTRL_CLR_ON_READ_EN
  localparam bit CLR_ON_READ = 1'b1;
`else
  localparam bit CLR_ON_READ = 1'b0;
`endif

  typedef struct {
    int              tag;
    logic [NCH-1:0]  xoff;
    logic [NCH-1:0]  xon;
    logic [NCH-1:0]  paused;
    logic            rv;
    logic [CW-1:0]   rd;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cycle = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   xoff0_seen = 0;
  int   xon0_seen = 0;
  exp_t exp_q [$];

  int m_cnt [NCH][4];
  bit m_paused [NCH];
  int m_next [NCH];
  bit m_prev_xoff [NCH];
  int m_rd_last = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  mac_flow_ctrl_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

  mac_flow_ctrl #(
    .NUM_CH       (NCH),
    .CNT_W        (CW),
    .XOFF_REFRESH (REFRESH),
    .ERR_MASK     (MASK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference: pause decisions by absolute cycle of the next refresh check, counters as saturating ints.
  task automatic model_step();
    exp_t        e;
    int          inc [4];
    logic [17:0] err;
    bit          xo, xn, af, ae;
    e.tag = cycle + 1;
    e.xoff = '0;
    e.xon = '0;
    e.paused = '0;
    e.rv = 1'b0;
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        for (int s = 0; s < 4; s++) m_cnt[c][s] = 0;
        m_paused[c] = 0;
        m_prev_xoff[c] = 0;
      end
      m_rd_last = 0;
    end else begin
      if (bus.rd_en) begin
        e.rv = 1'b1;
        m_rd_last = 0;
        if (int'(bus.rd_ch) < NCH) m_rd_last = m_cnt[bus.rd_ch][bus.rd_sel];
      end
      for (int c = 0; c < NCH; c++) begin
        err = bus.rx_err_stat[c*18 +: 18];
        af = bus.ff_rx_a_full[c];
        ae = bus.ff_rx_a_empty[c];
        inc[0] = int'(bus.rx_stat_vld[c]);
        inc[1] = int'(bus.rx_stat_vld[c] && ((err & MASK) != 0));
        inc[2] = int'(bus.rx_stat_vld[c] && bus.rx_frm_type[c*4+2]);
        inc[3] = int'(m_prev_xoff[c]);
        for (int s = 0; s < 4; s++) begin
          if (CLR_ON_READ && bus.rd_en && int'(bus.rd_ch) == c && int'(bus.rd_sel) == s)
            m_cnt[c][s] = inc[s];
          else if (m_cnt[c][s] + inc[s] > MAXV)
            m_cnt[c][s] = MAXV;
          else
            m_cnt[c][s] = m_cnt[c][s] + inc[s];
        end
        xo = 0;
        xn = 0;
        if (!m_paused[c]) begin
          if (af) begin
            m_paused[c] = 1;
            xo = 1;
            m_next[c] = cycle + REFRESH;
          end
        end else if (ae && !af) begin
          m_paused[c] = 0;
          xn = 1;
        end else if (cycle == m_next[c]) begin
          m_next[c] = cycle + REFRESH;
          xo = af;
        end
        e.xoff[c] = xo;
        e.xon[c] = xn;
        e.paused[c] = m_paused[c];
        m_prev_xoff[c] = xo;
      end
    end
    e.rd = CW'(m_rd_last);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic read_now(input int ch, input int sel, output int val);
    bus.rd_en = 1'b1;
    bus.rd_ch = 3'(ch);
    bus.rd_sel = 2'(sel);
    tick();
    bus.rd_en = 1'b0;
    val = int'(bus.rd_data);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].tag == cycle) begin
      e = exp_q.pop_front();
      n_chk++;
      if ({bus.xoff_gen, bus.xon_gen, bus.paused} !== {e.xoff, e.xon, e.paused}) begin
        n_fail++;
        $display("FAIL flow cyc %0d: xoff/xon/paused got %b/%b/%b expected %b/%b/%b",
                 cycle, bus.xoff_gen, bus.xon_gen, bus.paused, e.xoff, e.xon, e.paused);
      end
      n_chk++;
      if (bus.rd_valid !== e.rv || bus.rd_data !== e.rd) begin
        n_fail++;
        $display("FAIL read cyc %0d: valid/data got %b/%0d expected %b/%0d",
                 cycle, bus.rd_valid, bus.rd_data, e.rv, e.rd);
      end
      if (bus.xoff_gen[0] === 1'b1) xoff0_seen++;
      if (bus.xon_gen[0] === 1'b1) xon0_seen++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int v, x0, xn0, lvl;
    bus.ff_rx_a_full = '0;
    bus.ff_rx_a_empty = '0;
    bus.rx_stat_vld = '0;
    bus.rx_err_stat = '0;
    bus.rx_frm_type = '0;
    bus.rd_en = 1'b0;
    bus.rd_ch = '0;
    bus.rd_sel = '0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_paused", int'(bus.paused), 0);
    chk("reset_rd_data", int'(bus.rd_data), 0);
    tick();

    x0 = xoff0_seen;
    bus.ff_rx_a_full[0] = 1'b1;
    tick();
    chk("xoff_first_pulse", int'(bus.xoff_gen[0]), 1);
    chk("paused_on_entry", int'(bus.paused[0]), 1);
    repeat (19) tick();
    bus.ff_rx_a_full[0] = 1'b0;
    chk("xoff_pulses_held", xoff0_seen - x0, 3);
    read_now(0, SEL_XOFF, v);
    chk("xoff_count", v, 3);
    repeat (6) tick();
    xn0 = xon0_seen;
    bus.ff_rx_a_empty[0] = 1'b1;
    tick();
    bus.ff_rx_a_empty[0] = 1'b0;
    chk("xon_pulse", int'(bus.xon_gen[0]), 1);
    chk("paused_after_xon", int'(bus.paused[0]), 0);
    tick();
    bus.ff_rx_a_full[0] = 1'b1;
    bus.ff_rx_a_empty[0] = 1'b1;
    repeat (12) tick();
    chk("no_xon_when_both", xon0_seen - xn0, 1);

    bus.ff_rx_a_full[0] = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("paused_after_reset", int'(bus.paused[0]), 0);
    xn0 = xon0_seen;
    repeat (3) tick();
    bus.ff_rx_a_empty[0] = 1'b0;
    chk("no_xon_after_reset", xon0_seen - xn0, 0);

    bus.rx_stat_vld[1] = 1'b1;
    bus.rx_err_stat[18 +: 18] = 18'h1;
    repeat (300) tick();
    bus.rx_stat_vld[1] = 1'b0;
    read_now(1, SEL_FRAMES, v);
    chk("frames_saturate", v, MAXV);
    read_now(1, SEL_ERRORED, v);
    chk("errored_saturate", v, MAXV);
    read_now(1, SEL_BCAST, v);
    chk("bcast_zero", v, 0);
    read_now(5, SEL_FRAMES, v);
    chk("bad_channel_zero", v, 0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.rx_stat_vld[0] = 1'b1;
    bus.rx_err_stat[0 +: 18] = 18'h0;
    repeat (5) tick();
    read_now(0, SEL_FRAMES, v);
    bus.rx_stat_vld[0] = 1'b0;
    chk("read_before_inc", v, 5);
    read_now(0, SEL_FRAMES, v);
    chk("read_after_same_cycle_inc", v, CLR_ON_READ ? 1 : 6);

    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 9) == 0) begin
          lvl = int'($urandom_range(0, 3));
          bus.ff_rx_a_full[c] = lvl[0];
          bus.ff_rx_a_empty[c] = lvl[1];
        end
        bus.rx_stat_vld[c] = ($urandom_range(0, 2) == 0);
        bus.rx_err_stat[c*18 +: 18] = ($urandom_range(0, 1) == 0) ? 18'h0 : 18'($urandom);
        bus.rx_frm_type[c*4 +: 4] = 4'($urandom);
      end
      bus.rd_en = ($urandom_range(0, 1) == 1);
      bus.rd_ch = 3'($urandom_range(0, 7));
      bus.rd_sel = 2'($urandom);
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;
    bus.rd_en = 1'b0;
    bus.rx_stat_vld = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
